// File: rtl/led_seq_pkg.sv
// Shared constants, state encoding and pattern helpers for the LED sequencer.
// Helpers work on a 32-bit pattern; callers keep the low LEDS bits.
package led_seq_pkg;

  localparam logic [1:0] MODE_SHL   = 2'd0;
  localparam logic [1:0] MODE_SHR   = 2'd1;
  localparam logic [1:0] MODE_PING  = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // led occupies the upper bits so a (LEDS+1)-bit cast keeps {led, dir}
  typedef struct packed {
    logic [31:0] led;
    logic        dir;
  } step_t;

  function automatic logic [31:0] pattern_mask(input int unsigned leds);
    return (leds >= 32) ? 32'hFFFF_FFFF : ((32'd1 << leds) - 32'd1);
  endfunction

  function automatic logic [31:0] init_pattern(input logic [1:0] mode, input int unsigned leds);
    logic [31:0] p;
    p = 32'd1;
    if (mode == MODE_SHR) p = 32'd1 << (leds - 32'd1);
    else if (mode == MODE_BLINK) p = pattern_mask(leds);
    return p;
  endfunction

  function automatic int unsigned pass_len(input logic [1:0] mode, input int unsigned leds);
    int unsigned n;
    case (mode)
      MODE_SHL, MODE_SHR: n = leds;
      MODE_PING:          n = 2 * (leds - 1);
      default:            n = 2;
    endcase
    return n;
  endfunction

  // One animation step; PING flips direction on reaching either end.
  function automatic step_t step_pattern(input logic [1:0] mode, input logic [31:0] led,
                                         input logic dir, input int unsigned leds);
    logic [4:0]  top;
    logic [31:0] mask;
    step_t       r;
    top   = 5'(leds - 32'd1);
    mask  = pattern_mask(leds);
    r.led = led;
    r.dir = dir;
    case (mode)
      MODE_SHL: r.led = ((led << 1) | {31'd0, led[top]}) & mask;
      MODE_SHR: r.led = (led >> 1) | (led[0] ? (32'd1 << top) : 32'd0);
      MODE_PING: begin
        if (dir == DIR_UP) begin
          r.led = led << 1;
          if (r.led[top]) r.dir = DIR_DOWN;
        end else begin
          r.led = led >> 1;
          if (r.led[0]) r.dir = DIR_UP;
        end
      end
      default: r.led = ~led & mask;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: steps an LED bank on pulse-generator ticks through
// one of four animations, for REPEAT passes or until stopped.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int unsigned LEDS   = 8,
  parameter int unsigned REPEAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic [1:0]      mode,
  input  logic            start,
  input  logic            stop,
  output logic [LEDS-1:0] led,
  output logic            busy,
  output logic            done
);

  localparam int unsigned STEP_W = $clog2(2 * LEDS);
  localparam int unsigned PASS_W = ($clog2(REPEAT + 1) > 1) ? $clog2(REPEAT + 1) : 1;
  localparam int unsigned RES_W  = LEDS + 1;

  state_e            state_q;
  logic [1:0]        mode_q;
  logic [LEDS-1:0]   led_q;
  logic [LEDS-1:0]   led_d;
  logic [LEDS-1:0]   led_init_c;
  logic              dir_q;
  logic              dir_d;
  logic [STEP_W-1:0] step_q;
  logic [PASS_W-1:0] pass_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_end_c;
  logic              last_pass_c;

  always_comb begin
    {led_d, dir_d} = RES_W'(step_pattern(mode_q, 32'(led_q), dir_q, LEDS));
  end

  assign led_init_c  = LEDS'(init_pattern(mode, LEDS));
  assign pass_end_c  = (32'(step_q) == pass_len(mode_q, LEDS) - 32'd1);
  assign last_pass_c = (REPEAT != 0) && (32'(pass_q) == REPEAT - 32'd1);

  // Sequencer FSM with registered outputs; stop wins over tick and start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SHL;
      led_q   <= '0;
      dir_q   <= DIR_UP;
      step_q  <= '0;
      pass_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            state_q <= ST_RUN;
            mode_q  <= mode;
            led_q   <= led_init_c;
            dir_q   <= DIR_UP;
            step_q  <= '0;
            pass_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_q <= ST_IDLE;
            led_q   <= '0;
            dir_q   <= DIR_UP;
            busy_q  <= 1'b0;
          end else if (tick) begin
            if (pass_end_c && last_pass_c) begin
              state_q <= ST_DONE;
              led_q   <= '0;
              dir_q   <= DIR_UP;
              step_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              led_q <= led_d;
              dir_q <= dir_d;
              if (pass_end_c) begin
                step_q <= '0;
                pass_q <= pass_q + PASS_W'(1);
              end else begin
                step_q <= step_q + STEP_W'(1);
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench: a step-count reference model predicts {led,busy,done}
// per cycle for a REPEAT=2 and a REPEAT=0 instance sharing one stimulus.
module tb_led_seq_ctrl;

  localparam int REP_A = 2;
  localparam int REP_B = 0;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick  = 1'b0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic [1:0] mode  = 2'd0;
  logic [7:0] led_a, led_b;
  logic       busy_a, busy_b, done_a, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  led_seq_ctrl #(.LEDS(8), .REPEAT(REP_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .mode(mode), .start(start), .stop(stop),
    .led(led_a), .busy(busy_a), .done(done_a));

  led_seq_ctrl #(.LEDS(8), .REPEAT(REP_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .mode(mode), .start(start), .stop(stop),
    .led(led_b), .busy(busy_b), .done(done_b));

  // Reference model: pattern is a closed-form function of steps taken since start.
  int m_st[2];
  int m_mode[2];
  int m_k[2];
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];

  function automatic logic [7:0] pat(input int md, input int k);
    int p;
    case (md)
      0: return 8'(1 << (k % 8));
      1: return 8'(1 << (7 - (k % 8)));
      2: begin
        p = k % 14;
        return 8'(1 << ((p <= 7) ? p : 14 - p));
      end
      default: return ((k % 2) == 0) ? 8'hFF : 8'h00;
    endcase
  endfunction

  function automatic int plen(input int md);
    return (md == 2) ? 14 : (md == 3) ? 2 : 8;
  endfunction

  task automatic model_step(input int i, input int rep, output logic [9:0] e);
    if (!rst_n) begin
      m_st[i] = 0;
    end else begin
      case (m_st[i])
        0: if (start && !stop) begin
          m_st[i] = 1; m_mode[i] = int'(mode); m_k[i] = 0;
        end
        1: if (stop) m_st[i] = 0;
           else if (tick) begin
             m_k[i] = m_k[i] + 1;
             if (rep != 0 && m_k[i] == rep * plen(m_mode[i])) m_st[i] = 2;
           end
        default: m_st[i] = 0;
      endcase
    end
    case (m_st[i])
      1:       e = {pat(m_mode[i], m_k[i]), 2'b10};
      2:       e = 10'b00000000_01;
      default: e = 10'h000;
    endcase
  endtask

  always @(posedge clk) begin
    logic [9:0] ea, eb;
    model_step(0, REP_A, ea);
    model_step(1, REP_B, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
  end

  // Asynchronous reset overrides the prediction made at the last edge.
  always @(negedge rst_n) begin
    m_st[0] = 0;
    m_st[1] = 0;
    if (q_a.size() > 0) q_a[q_a.size()-1] = 10'h000;
    if (q_b.size() > 0) q_b[q_b.size()-1] = 10'h000;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    if (q_a.size() == 0) chk("scoreboard_a_empty", 32'd1, 32'd0);
    else begin
      e = q_a.pop_front();
      chk("dut_a {led,busy,done}", 32'({led_a, busy_a, done_a}), 32'(e));
    end
    if (q_b.size() == 0) chk("scoreboard_b_empty", 32'd1, 32'd0);
    else begin
      e = q_b.pop_front();
      chk("dut_b {led,busy,done}", 32'({led_b, busy_b, done_b}), 32'(e));
    end
  end

  task automatic cyc(input logic t, input logic s, input logic p, input logic [1:0] m);
    tick = t; start = s; stop = p; mode = m;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic resync();
    cyc(1'b0, 1'b0, 1'b1, 2'd0);
    idle(1);
  endtask

  initial begin
    // Reset held while tick and start toggle
    for (int i = 0; i < 6; i++) cyc(1'($urandom), 1'($urandom), 1'b0, 2'($urandom));
    rst_n = 1'b1;
    idle(2);

    // SHL full run, back-to-back ticks
    cyc(1'b0, 1'b1, 1'b0, 2'd0);
    repeat (16) cyc(1'b1, 1'b0, 1'b0, 2'd0);
    idle(3);
    resync();

    // PING, start with a same-cycle tick that must be discarded
    cyc(1'b1, 1'b1, 1'b0, 2'd2);
    for (int i = 0; i < 28; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 2'd0);
      cyc(1'b0, 1'b0, 1'b0, 2'd0);
    end
    idle(3);
    resync();

    // Stop beats a coincident tick at led = 0x08
    cyc(1'b0, 1'b1, 1'b0, 2'd0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 2'd0);
    cyc(1'b1, 1'b0, 1'b1, 2'd0);
    idle(3);

    // BLINK ignores start and mode changes while running
    cyc(1'b0, 1'b1, 1'b0, 2'd3);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 2'd0);
      cyc(1'b0, 1'b1, 1'b0, 2'd1);
    end
    resync();

    // Ticks in IDLE
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 2'd0);

    // SHR, 100 ticks: REPEAT=0 instance keeps running
    cyc(1'b0, 1'b1, 1'b0, 2'd1);
    repeat (100) cyc(1'b1, 1'b0, 1'b0, 2'd0);
    idle(2);
    resync();

    // Reset asserted mid-run between clock edges
    cyc(1'b0, 1'b1, 1'b0, 2'd2);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 2'd0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_a", 32'({led_a, busy_a, done_a}), 32'd0);
    chk("async_reset_b", 32'({led_b, busy_b, done_b}), 32'd0);
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 29) == 0, 2'($urandom));
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
